button_tick_conditioner: RTL and testbench



---
 rtl/button_tick_conditioner_pkg.sv | 23 ++
 rtl/button_tick_conditioner_if.sv | 37 +++
 rtl/button_tick_conditioner_tick_prescaler.sv | 45 ++++
 rtl/button_tick_conditioner.sv | 137 +++++++++++++
 tb/tb_button_tick_conditioner.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_tick_conditioner_pkg.sv
// button_tick_conditioner_pkg
//   Shared definitions for the button/tick input-conditioning slice:
//   debounce FSM state encoding and elaboration-time parameter checks.
//   No ports.

// Elaboration-time lower-bound check on an integer parameter.
`define BTC_PARAM_MIN(P, MIN) \
  if ((P) < (MIN)) begin : g_param_range_chk \
    $error("parameter P below its minimum value MIN"); \
  end

package button_tick_conditioner_pkg;

  // Debounce FSM states; the encoding is fixed so that state bit 1 equals
  // the accepted level and bit 0 marks a pending (counting) transition.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } deb_state_e;

endpackage

// File: rtl/button_tick_conditioner_if.sv
// button_tick_conditioner_if
//   Groups the conditioner's pin-side and strobe-side signals.
//   btn_in      raw asynchronous button pin, active-high
//   tick_en     prescaler enable
//   btn_level   debounced button level
//   btn_press   one-cycle strobe on accepted 0->1 transition
//   btn_release one-cycle strobe on accepted 1->0 transition
//   tick        one-cycle strobe every PRESCALE enabled cycles
//   master: drives btn_in/tick_en, observes outputs (stimulus / consumer side)
//   slave : the conditioner itself

interface button_tick_conditioner_if;
  logic btn_in;
  logic tick_en;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic tick;

  modport master (
    output btn_in,
    output tick_en,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  tick
  );

  modport slave (
    input  btn_in,
    input  tick_en,
    output btn_level,
    output btn_press,
    output btn_release,
    output tick
  );
endinterface

// File: rtl/button_tick_conditioner_tick_prescaler.sv
// tick_prescaler
//   Programmable-rate strobe generator. While tick_en is high, tick pulses
//   for one cycle every PRESCALE enabled cycles; dropping tick_en discards
//   the partial count. PRESCALE=1 gives tick held high while enabled.
//   clk     system clock, rising edge
//   reset   synchronous reset, active-high
//   tick_en count enable
//   tick    registered rate strobe

module tick_prescaler #(
  parameter  int unsigned PRESCALE = 50000000,
  localparam int unsigned PS_W     = $clog2(PRESCALE + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  output logic tick
);
  import button_tick_conditioner_pkg::*;

  `BTC_PARAM_MIN(PRESCALE, 1)

  localparam logic [PS_W-1:0] LP_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_pcnt;
  logic            r_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else if (!tick_en) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else if (r_pcnt == LP_LAST) begin
      r_pcnt <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pcnt <= r_pcnt + PS_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;
endmodule

// File: rtl/button_tick_conditioner.sv
// button_tick_conditioner
//   Input-conditioning stage: synchronizes and debounces a raw push-button
//   into a level plus press/release strobes, and generates a prescaled
//   tick strobe. Debouncer and prescaler are independent.
//   clk    system clock, rising edge
//   reset  synchronous reset, active-high (dominates all inputs)
//   bus    slave side of button_tick_conditioner_if
//            btn_in, tick_en                          inputs
//            btn_level, btn_press, btn_release, tick  registered outputs

module button_tick_conditioner #(
  parameter  int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter  int unsigned PRESCALE        = 50000000,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  button_tick_conditioner_if.slave    bus
);
  import button_tick_conditioner_pkg::*;

  `BTC_PARAM_MIN(DEBOUNCE_CYCLES, 2)

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizer; only r_sync2 is consumed downstream.
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM: a transition is accepted after DEBOUNCE_CYCLES
  // consecutive synchronized samples at the new level.
  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_press;
  logic             w_press_nxt;
  logic             r_release;
  logic             w_release_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (r_sync2) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!r_sync2) begin
          // bounce: abandon the pending press silently
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (r_sync2) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt   = IDLE_LOW;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  logic w_tick;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clk     (clk),
    .reset   (reset),
    .tick_en (bus.tick_en),
    .tick    (w_tick)
  );

  assign bus.btn_level   = r_level;
  assign bus.btn_press   = r_press;
  assign bus.btn_release = r_release;
  assign bus.tick        = w_tick;
endmodule

// File: tb/tb_button_tick_conditioner.sv
// tb_button_tick_conditioner
//   Two conditioners (PRESCALE=3 and PRESCALE=1, both DEBOUNCE_CYCLES=4)
//   share the same stimulus and are compared every cycle against a
//   behavioural model: the debounced level flips after D consecutive
//   synchronized samples that disagree with it; tick fires on every
//   PRESCALE-th consecutive enabled edge.

module tb_button_tick_conditioner;
  import button_tick_conditioner_pkg::*;

  localparam int D  = 4;
  localparam int PA = 3;
  localparam int PB = 1;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic tick_en;

  always #5 clk = ~clk;

  button_tick_conditioner_if bus_a ();
  button_tick_conditioner_if bus_b ();

  assign bus_a.btn_in  = btn_in;
  assign bus_a.tick_en = tick_en;
  assign bus_b.btn_in  = btn_in;
  assign bus_b.tick_en = tick_en;

  button_tick_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .PRESCALE        (PA)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  button_tick_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .PRESCALE        (PB)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  int m_hist [2] = '{0, 0};
  int m_level    = 0;
  int m_run      = 0;
  int m_press    = 0;
  int m_rel      = 0;
  int m_prun     = 0;
  int m_ta       = 0;
  int m_tb       = 0;

  // {level, press, release, tick} for dut_a then dut_b
  logic [7:0] exp_v;
  logic [7:0] obs_v;

  task automatic step(input logic r, input logic b, input logic e);
    int sync;
    reset   = r;
    btn_in  = b;
    tick_en = e;
    @(posedge clk);
    if (r) begin
      m_hist  = '{0, 0};
      m_level = 0; m_run = 0; m_press = 0; m_rel = 0;
      m_prun  = 0; m_ta = 0; m_tb = 0;
    end else begin
      sync    = m_hist[1];
      m_press = 0;
      m_rel   = 0;
      if (sync != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = sync;
          if (sync != 0) m_press = 1; else m_rel = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_hist[1] = m_hist[0];
      m_hist[0] = int'(b);
      if (e) begin
        m_prun++;
        m_ta = int'(m_prun % PA == 0);
        m_tb = int'(m_prun % PB == 0);
      end else begin
        m_prun = 0; m_ta = 0; m_tb = 0;
      end
    end
    #1;
    exp_v = {m_level[0], m_press[0], m_rel[0], m_ta[0],
             m_level[0], m_press[0], m_rel[0], m_tb[0]};
    obs_v = {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.tick,
             bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, bus_b.tick};
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b1);
      n_cmp++;
      if (obs_v !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_outputs k=%0d got=%b want=%b", k, obs_v, 8'h00);
      end
    end
  endtask

  task automatic test_clean_press();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL clean_press_model k=%0d got=%b want=%b", k, obs_v, exp_v);
      end
      n_cmp++;
      if (obs_v[6] !== (k == 5) || obs_v[7] !== (k >= 5)) begin
        n_bad++;
        $display("FAIL clean_press_timing k=%0d got press=%b level=%b want press=%b level=%b",
                 k, obs_v[6], obs_v[7], (k == 5), (k >= 5));
      end
    end
  endtask

  task automatic test_bounce();
    logic [12:0] pat;
    pat = 13'b0000000_011011;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) begin
      step(1'b0, pat[k], 1'b0);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[7:6] !== 2'b00) begin
        n_bad++;
        $display("FAIL bounce k=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (dut_a.r_state !== IDLE_LOW) begin
      n_bad++;
      $display("FAIL bounce_state got=%0d want=%0d", dut_a.r_state, IDLE_LOW);
    end
  endtask

  task automatic test_release();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs_v[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL release_setup got level=%b want=1", obs_v[7]);
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[5] !== (k == 5) || obs_v[7] !== (k < 5)
          || obs_v[6] !== 1'b0) begin
        n_bad++;
        $display("FAIL release k=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_prescaler();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[4] !== (k % 3 == 0) || obs_v[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL prescaler k=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[4] !== 1'b0) begin
        n_bad++;
        $display("FAIL prescaler_disabled k=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[4] !== (k == 3)) begin
        n_bad++;
        $display("FAIL prescaler_reenable k=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[0] !== 1'b1 || obs_v[2] !== (k == 5)) begin
        n_bad++;
        $display("FAIL simultaneous k=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[6] !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_reset_pre k=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (obs_v !== 8'h00) begin
        n_bad++;
        $display("FAIL mid_reset_during k=%0d got=%b want=%b", k, obs_v, 8'h00);
      end
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[6] !== (k == 5)) begin
        n_bad++;
        $display("FAIL mid_reset_post k=%0d got=%b want=%b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    int   run_left;
    logic b;
    logic e;
    logic r;
    logic prev_press;
    run_left   = 0;
    b          = 1'b0;
    e          = 1'b0;
    prev_press = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (run_left == 0) begin
        b        = 1'($urandom_range(0, 1));
        run_left = int'($urandom_range(1, 8));
      end
      run_left--;
      if ($urandom_range(0, 9) == 0) e = ~e;
      r = ($urandom_range(0, 149) == 0);
      step(r, b, e);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL random i=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      n_cmp++;
      if ((obs_v[6] && obs_v[5]) || (obs_v[6] && prev_press)) begin
        n_bad++;
        $display("FAIL random_strobe_rules i=%0d got press=%b release=%b prev_press=%b want no overlap",
                 i, obs_v[6], obs_v[5], prev_press);
      end
      prev_press = obs_v[6];
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_in  = 1'b0;
    tick_en = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_prescaler();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
